// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
// Widths are derived from module parameters through the functions below.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Ceiling log2 with a floor of 1 so derived vectors never collapse to zero width.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int id_width(input int num_req);
        return clog2(num_req);
    endfunction

    function automatic int beat_width(input int burst_len);
        return clog2(burst_len + 1);
    endfunction

    function automatic int idle_width(input int idle_timeout);
        return clog2(idle_timeout + 1);
    endfunction

    localparam int DEF_NUM_REQ      = 4;
    localparam int DEF_BURST_LEN    = 16;
    localparam int DEF_IDLE_TIMEOUT = 8;
    localparam int DEF_ID_W         = id_width(DEF_NUM_REQ);
    localparam int DEF_BEAT_W       = beat_width(DEF_BURST_LEN);
    localparam int DEF_IDLE_W       = idle_width(DEF_IDLE_TIMEOUT);

endpackage

// File: rtl/fifo_arb_rr_pick.sv
// Rotating-priority picker: first set request at or after rr_ptr, searching upward
// with wrap-around, found by scanning a double-width {req, masked req} vector.
module fifo_arb_rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic               any,
    output logic [ID_W-1:0]    idx
);

    localparam int POS_W = clog2(2 * NUM_REQ);

    logic [NUM_REQ-1:0]   upper_mask;
    logic [2*NUM_REQ-1:0] dbl_req;
    logic [POS_W-1:0]     pos;
    logic                 found;

    // The low half only keeps requesters at or above the pointer, so the lowest set
    // bit of the doubled vector is the rotating winner; the high half supplies the wrap.
    always_comb begin
        upper_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            upper_mask[i] = (i >= int'(rr_ptr));
        end
        dbl_req = {req, req & upper_mask};
        pos     = '0;
        found   = 1'b0;
        for (int i = 0; i < 2 * NUM_REQ; i++) begin
            if (dbl_req[i] && !found) begin
                pos   = POS_W'(i);
                found = 1'b1;
            end
        end
    end

    assign any = |req;
    assign idx = (pos >= POS_W'(NUM_REQ)) ? ID_W'(pos - POS_W'(NUM_REQ)) : ID_W'(pos);

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst-locked round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// A grant ends on last, on the beat limit, or after an idle timeout.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ      = DEF_NUM_REQ,
    parameter int DATA_WIDTH   = 32,
    parameter int BURST_LEN    = DEF_BURST_LEN,
    parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT,
    parameter int ID_W         = id_width(NUM_REQ)
) (
    input  logic                          wr_clk,
    input  logic                          wr_rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    input  logic                          fifo_wr_vld,
    output logic [ID_W-1:0]               grant_id,
    output logic                          busy,
    output logic                          burst_done
);

    localparam int BEAT_W = beat_width(BURST_LEN);
    localparam int IDLE_W = idle_width(IDLE_TIMEOUT);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);
    localparam logic [ID_W:0]     REQ_COUNT = (ID_W + 1)'(NUM_REQ);

    arb_state_t state, state_nxt;

    logic [ID_W-1:0]       grant_q;
    logic [ID_W-1:0]       rr_ptr_q;
    logic [BEAT_W-1:0]     beat_cnt_q;
    logic [IDLE_W-1:0]     idle_cnt_q;
    logic                  busy_q;
    logic                  done_q;

    logic                  pick_any;
    logic [ID_W-1:0]       pick_idx;
    logic                  cur_valid;
    logic                  cur_last;
    logic                  in_burst;
    logic                  beat;
    logic                  grant_end;
    logic [ID_W:0]         grant_inc;
    logic [ID_W-1:0]       rr_next;
    logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

    fifo_arb_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req    (req_valid),
        .rr_ptr (rr_ptr_q),
        .any    (pick_any),
        .idx    (pick_idx)
    );

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign cur_valid = req_valid[grant_q];
    assign cur_last  = req_last[grant_q];
    assign in_burst  = (state == BURST);
    assign beat      = in_burst & cur_valid & fifo_wr_vld;

    // Back-pressure holds everything, so the timeout only fires on a cycle the FIFO could accept.
    assign grant_end = (beat & (cur_last | (beat_cnt_q == BEAT_LAST)))
                     | (in_burst & fifo_wr_vld & ~cur_valid & (idle_cnt_q == IDLE_LAST));

    assign grant_inc = {1'b0, grant_q} + 1'b1;
    assign rr_next   = (grant_inc == REQ_COUNT) ? '0 : grant_inc[ID_W-1:0];

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        req_ready    = '0;
        fifo_wr_en   = 1'b0;
        fifo_wr_data = data_arr[grant_q];
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_nxt = BURST;
                end
            end
            BURST: begin
                fifo_wr_en         = cur_valid;
                req_ready[grant_q] = fifo_wr_vld;
                if (grant_end) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            idle_cnt_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state == IDLE) begin
                if (pick_any) begin
                    grant_q    <= pick_idx;
                    busy_q     <= 1'b1;
                    beat_cnt_q <= '0;
                    idle_cnt_q <= '0;
                end
            end else begin
                if (beat) begin
                    beat_cnt_q <= beat_cnt_q + 1'b1;
                end
                if (cur_valid) begin
                    idle_cnt_q <= '0;
                end else if (fifo_wr_vld) begin
                    idle_cnt_q <= idle_cnt_q + 1'b1;
                end
                if (grant_end) begin
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    rr_ptr_q <= rr_next;
                end
            end
        end
    end

    assign grant_id   = grant_q;
    assign busy       = busy_q;
    assign burst_done = done_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios with hand-derived timelines,
// then random traffic against a behavioural grant model.
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int BL = 4;
    localparam int IT = 8;

    logic           wr_clk = 1'b0;
    logic           wr_rst = 1'b1;
    logic [NR-1:0]  req_valid = '0;
    logic [NR*DW-1:0] req_data = '0;
    logic [NR-1:0]  req_last = '0;
    logic [NR-1:0]  req_ready;
    logic           fifo_wr_en;
    logic [DW-1:0]  fifo_wr_data;
    logic           fifo_wr_vld = 1'b1;
    logic [1:0]     grant_id;
    logic           busy;
    logic           burst_done;

    int n_vec = 0;
    int n_err = 0;

    fifo_wr_arbiter #(
        .NUM_REQ      (NR),
        .DATA_WIDTH   (DW),
        .BURST_LEN    (BL),
        .IDLE_TIMEOUT (IT)
    ) dut (
        .wr_clk       (wr_clk),
        .wr_rst       (wr_rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .fifo_wr_vld  (fifo_wr_vld),
        .grant_id     (grant_id),
        .busy         (busy),
        .burst_done   (burst_done)
    );

    always #5 wr_clk = ~wr_clk;

    task automatic set_word(input int i, input logic [DW-1:0] w);
        req_data[i*DW +: DW] = w;
    endtask

    task automatic do_reset();
        @(negedge wr_clk);
        wr_rst      = 1'b1;
        req_valid   = '0;
        req_last    = '0;
        req_data    = '0;
        fifo_wr_vld = 1'b1;
        @(negedge wr_clk);
        wr_rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge wr_clk);
        #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy got=%0b exp=0", busy); end
        n_vec++; if (grant_id !== 2'd0) begin n_err++; $display("[TB] FAIL reset_grant got=%0d exp=0", grant_id); end
        n_vec++; if (burst_done !== 1'b0) begin n_err++; $display("[TB] FAIL reset_done got=%0b exp=0", burst_done); end
        n_vec++; if (req_ready !== 4'b0) begin n_err++; $display("[TB] FAIL reset_ready got=%b exp=0000", req_ready); end
        n_vec++; if (fifo_wr_en !== 1'b0) begin n_err++; $display("[TB] FAIL reset_wr_en got=%0b exp=0", fifo_wr_en); end
        req_valid = 4'b1111;
        @(negedge wr_clk);
        #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL reset_hold_busy got=%0b exp=0", busy); end
        wr_rst    = 1'b0;
        req_valid = '0;
    endtask

    task automatic test_single();
        int k;
        k = 0;
        do_reset();
        for (int c = 0; c < 7; c++) begin
            @(negedge wr_clk);
            req_valid   = '0;
            req_last    = '0;
            fifo_wr_vld = 1'b1;
            if (c < 5) begin
                req_valid[2] = (k < 3);
                req_last[2]  = (k == 2);
                set_word(2, 32'hA000_0000 + 32'(k));
            end else begin
                req_valid = 4'b1001;
            end
            #1;
            if (c >= 1 && c <= 3) begin
                n_vec++; if (busy !== 1'b1 || grant_id !== 2'd2) begin n_err++; $display("[TB] FAIL single_grant c=%0d got busy=%0b id=%0d exp busy=1 id=2", c, busy, grant_id); end
                n_vec++; if (fifo_wr_en !== 1'b1 || req_ready !== 4'b0100) begin n_err++; $display("[TB] FAIL single_write c=%0d got en=%0b ready=%b exp en=1 ready=0100", c, fifo_wr_en, req_ready); end
                n_vec++; if (fifo_wr_data !== 32'hA000_0000 + 32'(c - 1)) begin n_err++; $display("[TB] FAIL single_data c=%0d got=%h exp=%h", c, fifo_wr_data, 32'hA000_0000 + 32'(c - 1)); end
            end else if (c == 0 || c == 5) begin
                n_vec++; if (busy !== 1'b0 || fifo_wr_en !== 1'b0 || req_ready !== 4'b0) begin n_err++; $display("[TB] FAIL single_idle c=%0d got busy=%0b en=%0b ready=%b exp 0/0/0000", c, busy, fifo_wr_en, req_ready); end
            end else if (c == 4) begin
                n_vec++; if (burst_done !== 1'b1 || busy !== 1'b0) begin n_err++; $display("[TB] FAIL single_done got done=%0b busy=%0b exp done=1 busy=0", burst_done, busy); end
            end else begin
                n_vec++; if (busy !== 1'b1 || grant_id !== 2'd3) begin n_err++; $display("[TB] FAIL single_rr_next got busy=%0b id=%0d exp busy=1 id=3", busy, grant_id); end
            end
            if (req_valid[2] && req_ready[2]) k++;
        end
    endtask

    task automatic test_fairness();
        int writes;
        writes = 0;
        do_reset();
        for (int c = 0; c < 22; c++) begin
            @(negedge wr_clk);
            req_valid   = 4'b1111;
            req_last    = '0;
            fifo_wr_vld = 1'b1;
            for (int i = 0; i < NR; i++) set_word(i, 32'h5000_0000 + 32'(i));
            #1;
            n_vec++; if (busy !== ((c % 5) != 0)) begin n_err++; $display("[TB] FAIL fair_busy c=%0d got=%0b exp=%0b", c, busy, (c % 5) != 0); end
            if ((c % 5) != 0) begin
                n_vec++; if (grant_id !== 2'((c / 5) % 4)) begin n_err++; $display("[TB] FAIL fair_grant c=%0d got=%0d exp=%0d", c, grant_id, (c / 5) % 4); end
            end
            n_vec++; if (burst_done !== ((c % 5) == 0 && c > 0)) begin n_err++; $display("[TB] FAIL fair_done c=%0d got=%0b exp=%0b", c, burst_done, (c % 5) == 0 && c > 0); end
            if (c < 20 && fifo_wr_en && fifo_wr_vld) writes++;
        end
        n_vec++; if (writes != 16) begin n_err++; $display("[TB] FAIL fair_beats got=%0d exp=16", writes); end
    endtask

    task automatic test_back_pressure();
        int k;
        int first_done_writes;
        logic [DW-1:0] seen[$];
        k = 0;
        first_done_writes = -1;
        do_reset();
        for (int c = 0; c < 25; c++) begin
            @(negedge wr_clk);
            req_valid    = '0;
            req_last     = '0;
            req_valid[1] = (k < 5);
            req_last[1]  = (k == 4);
            set_word(1, 32'h100 + 32'(k));
            fifo_wr_vld  = !(c >= 2 && c <= 4);
            #1;
            if (c >= 2 && c <= 4) begin
                n_vec++; if (fifo_wr_en !== 1'b1 || req_ready !== 4'b0) begin n_err++; $display("[TB] FAIL bp_stall c=%0d got en=%0b ready=%b exp en=1 ready=0000", c, fifo_wr_en, req_ready); end
            end
            if (fifo_wr_en && fifo_wr_vld) seen.push_back(fifo_wr_data);
            if (burst_done && first_done_writes < 0) first_done_writes = seen.size();
            if (req_valid[1] && req_ready[1]) k++;
        end
        n_vec++; if (seen.size() != 5) begin n_err++; $display("[TB] FAIL bp_count got=%0d exp=5", seen.size()); end
        for (int i = 0; i < seen.size() && i < 5; i++) begin
            n_vec++; if (seen[i] !== 32'h100 + 32'(i)) begin n_err++; $display("[TB] FAIL bp_order i=%0d got=%h exp=%h", i, seen[i], 32'h100 + 32'(i)); end
        end
        n_vec++; if (first_done_writes != 4) begin n_err++; $display("[TB] FAIL bp_split got=%0d exp=4", first_done_writes); end
    endtask

    task automatic test_timeout();
        int k0;
        k0 = 0;
        do_reset();
        for (int c = 0; c < 14; c++) begin
            @(negedge wr_clk);
            req_valid    = '0;
            req_last     = '0;
            fifo_wr_vld  = 1'b1;
            req_valid[0] = (k0 < 2);
            set_word(0, 32'hC0 + 32'(k0));
            req_valid[3] = 1'b1;
            req_last[3]  = 1'b1;
            set_word(3, 32'hD3);
            #1;
            if (c >= 1 && c <= 10) begin
                n_vec++; if (busy !== 1'b1 || grant_id !== 2'd0 || req_ready[3] !== 1'b0) begin n_err++; $display("[TB] FAIL to_hold c=%0d got busy=%0b id=%0d ready3=%0b exp 1/0/0", c, busy, grant_id, req_ready[3]); end
            end
            if (c >= 3 && c <= 10) begin
                n_vec++; if (fifo_wr_en !== 1'b0 || burst_done !== 1'b0) begin n_err++; $display("[TB] FAIL to_idle c=%0d got en=%0b done=%0b exp 0/0", c, fifo_wr_en, burst_done); end
            end
            if (c == 11) begin
                n_vec++; if (busy !== 1'b0 || burst_done !== 1'b1) begin n_err++; $display("[TB] FAIL to_release got busy=%0b done=%0b exp 0/1", busy, burst_done); end
            end
            if (c == 12) begin
                n_vec++; if (busy !== 1'b1 || grant_id !== 2'd3 || fifo_wr_data !== 32'hD3) begin n_err++; $display("[TB] FAIL to_next got busy=%0b id=%0d data=%h exp 1/3/d3", busy, grant_id, fifo_wr_data); end
            end
            if (req_valid[0] && req_ready[0]) k0++;
        end
    endtask

    task automatic test_last_limit();
        int k0;
        k0 = 0;
        do_reset();
        for (int c = 0; c < 9; c++) begin
            @(negedge wr_clk);
            req_valid    = 4'b0110;
            req_last     = '0;
            fifo_wr_vld  = 1'b1;
            req_valid[0] = (k0 < 4);
            req_last[0]  = (k0 == 3);
            set_word(0, 32'hE0 + 32'(k0));
            #1;
            n_vec++; if (burst_done !== (c == 5)) begin n_err++; $display("[TB] FAIL ll_done c=%0d got=%0b exp=%0b", c, burst_done, c == 5); end
            if (c == 6) begin
                n_vec++; if (busy !== 1'b1 || grant_id !== 2'd1) begin n_err++; $display("[TB] FAIL ll_next got busy=%0b id=%0d exp 1/1", busy, grant_id); end
            end
            if (req_valid[0] && req_ready[0]) k0++;
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int c = 0; c < 7; c++) begin
            @(negedge wr_clk);
            fifo_wr_vld = 1'b1;
            wr_rst      = (c == 4);
            set_word(1, 32'h11);
            set_word(2, 32'h22);
            if (c < 2) begin
                req_valid = 4'b0010;
                req_last  = 4'b0010;
            end else if (c < 5) begin
                req_valid = 4'b0100;
                req_last  = 4'b0000;
            end else begin
                req_valid = 4'b0110;
                req_last  = 4'b0000;
            end
            #1;
            if (c == 3) begin
                n_vec++; if (busy !== 1'b1 || grant_id !== 2'd2) begin n_err++; $display("[TB] FAIL mr_setup got busy=%0b id=%0d exp 1/2", busy, grant_id); end
            end
            if (c == 5) begin
                n_vec++; if (busy !== 1'b0 || fifo_wr_en !== 1'b0 || req_ready !== 4'b0) begin n_err++; $display("[TB] FAIL mr_clear got busy=%0b en=%0b ready=%b exp 0/0/0000", busy, fifo_wr_en, req_ready); end
                n_vec++; if (grant_id !== 2'd0 || burst_done !== 1'b0) begin n_err++; $display("[TB] FAIL mr_regs got id=%0d done=%0b exp 0/0", grant_id, burst_done); end
            end
            if (c == 6) begin
                n_vec++; if (busy !== 1'b1 || grant_id !== 2'd1) begin n_err++; $display("[TB] FAIL mr_regrant got busy=%0b id=%0d exp 1/1", busy, grant_id); end
            end
        end
        wr_rst = 1'b0;
    endtask

    // Reference model: owner (-1 when idle), rotating start point, beats and idle cycles of the grant.
    task automatic test_random();
        int m_owner, m_rr, m_beats, m_idle, p, o;
        logic m_done, fin, found;
        logic e_en;
        logic [NR-1:0] e_ready;
        logic [DW-1:0] e_data;
        int seq[NR];
        m_owner = -1; m_rr = 0; m_beats = 0; m_idle = 0; m_done = 1'b0;
        for (int i = 0; i < NR; i++) seq[i] = 0;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            @(negedge wr_clk);
            p = ((c % 200) < 100) ? 85 : (((c % 200) < 150) ? 40 : 5);
            for (int i = 0; i < NR; i++) begin
                req_valid[i] = ($urandom_range(99) < p);
                req_last[i]  = ($urandom_range(3) == 0);
                set_word(i, {8'(i), 24'(seq[i])});
            end
            fifo_wr_vld = ($urandom_range(99) < 80);
            #1;
            e_en    = (m_owner >= 0) ? req_valid[m_owner] : 1'b0;
            e_ready = (m_owner >= 0 && fifo_wr_vld) ? (4'b0001 << m_owner) : 4'b0000;
            e_data  = (m_owner >= 0) ? {8'(m_owner), 24'(seq[m_owner])} : '0;
            n_vec++; if (busy !== (m_owner >= 0)) begin n_err++; $display("[TB] FAIL rnd_busy c=%0d got=%0b exp=%0b", c, busy, m_owner >= 0); end
            if (m_owner >= 0) begin
                n_vec++; if (grant_id !== 2'(m_owner)) begin n_err++; $display("[TB] FAIL rnd_grant c=%0d got=%0d exp=%0d", c, grant_id, m_owner); end
            end
            n_vec++; if (fifo_wr_en !== e_en || req_ready !== e_ready) begin n_err++; $display("[TB] FAIL rnd_port c=%0d got en=%0b ready=%b exp en=%0b ready=%b", c, fifo_wr_en, req_ready, e_en, e_ready); end
            if (e_en) begin
                n_vec++; if (fifo_wr_data !== e_data) begin n_err++; $display("[TB] FAIL rnd_data c=%0d got=%h exp=%h", c, fifo_wr_data, e_data); end
            end
            n_vec++; if (burst_done !== m_done) begin n_err++; $display("[TB] FAIL rnd_done c=%0d got=%0b exp=%0b", c, burst_done, m_done); end

            m_done = 1'b0;
            if (m_owner < 0) begin
                found = 1'b0;
                for (int k = 0; k < NR; k++) begin
                    if (!found && req_valid[(m_rr + k) % NR]) begin
                        m_owner = (m_rr + k) % NR;
                        found   = 1'b1;
                    end
                end
                m_beats = 0;
                m_idle  = 0;
            end else begin
                o   = m_owner;
                fin = 1'b0;
                if (req_valid[o]) m_idle = 0;
                if (fifo_wr_vld) begin
                    if (req_valid[o]) begin
                        m_beats++;
                        fin = req_last[o] || (m_beats == BL);
                    end else begin
                        m_idle++;
                        fin = (m_idle == IT);
                    end
                end
                if (fin) begin
                    m_rr    = (o + 1) % NR;
                    m_owner = -1;
                    m_done  = 1'b1;
                end
            end
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i] && req_ready[i]) seq[i]++;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired before the test sequence completed");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_back_pressure();
        test_timeout();
        test_last_limit();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin arbiter that shares the write port of the 1024x32 prefetch FIFO (`async_fifo_1024x32b_prefetch`) between NUM_REQ producers in the write-clock domain. Grants are burst-locked: once granted, a producer owns the FIFO port until it signals last or reaches BURST_LEN beats, or until an idle timeout expires. Ownership is re-arbitrated with a rotating priority pointer. The block sits directly in front of the FIFO's wr_en/wr_vld/wr_data, and producers see a valid/ready interface.

## Interface
- NUM_REQ, 4: number of producers, 2..8
- DATA_WIDTH, 32: word width; must equal the FIFO write width
- BURST_LEN, 16: maximum beats per grant, 1..256
- IDLE_TIMEOUT, 8: consecutive granted cycles with no req_valid before the grant is released, 1..255
- wr_clk  in  1  FIFO write clock; the only clock
- wr_rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  producer i has a word
- req_data  in  NUM_REQ*DATA_WIDTH  producer i word at bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_last  in  NUM_REQ  producer i word is the final word of its packet
- req_ready  out  NUM_REQ  word of producer i is accepted this cycle when valid&ready
- fifo_wr_en  out  1  to FIFO wr_en
- fifo_wr_data  out  DATA_WIDTH  to FIFO wr_data
- fifo_wr_vld  in  1  from FIFO wr_vld; high means the FIFO accepts a write this cycle
- grant_id  out  clog2(NUM_REQ)  current owner; valid while busy
- busy  out  1  a grant is active
- burst_done  out  1  one-cycle pulse when a grant ends; see Operation for the cause

## Operation
- Reset values: state=IDLE, busy=0, grant_id=0, rr_ptr=0, beat_cnt=0, idle_cnt=0, req_ready=0, fifo_wr_en=0, burst_done=0.
- Beat definition: a beat is req_valid[g] & fifo_wr_vld while in state BURST.
- State IDLE:
  - Outputs: req_ready=0, fifo_wr_en=0.
  - If any req_valid is high, pick the first requester at or after rr_ptr, searching cyclically upward.
  - Register the winner as g, go to BURST, and clear beat_cnt and idle_cnt.
- State BURST:
  - fifo_wr_en = req_valid[g].
  - fifo_wr_data = req_data[g].
  - req_ready[g] = fifo_wr_vld; all other req_ready bits are 0.
- Beat counting: each beat increments beat_cnt (width clog2(BURST_LEN+1)).
- FIFO back-pressure: while fifo_wr_vld is low, the grant is held, beat_cnt freezes and idle_cnt does not count.
- Idle counting: when req_valid[g] is low, idle_cnt increments; any req_valid[g] high clears it.
- Grant termination goes to IDLE, pulses burst_done and sets rr_ptr = (g+1) mod NUM_REQ. It is triggered by any of:
  - a beat with req_last[g] high;
  - a beat with beat_cnt == BURST_LEN-1;
  - idle_cnt == IDLE_TIMEOUT-1 with req_valid[g] low.
- Simultaneous events: if last and the length limit coincide on one beat, the grant ends exactly once (single burst_done).
- Partial packets: a packet longer than BURST_LEN is split. The producer keeps its word order but must re-win arbitration to continue.
- Reset mid-burst: the next cycle is IDLE with all registers at reset values. The partial packet is abandoned; words already written stay in the FIFO.
- No other requester can be granted while busy, whatever its req_valid.

## Timing
- Arbitration latency: req_valid rising in IDLE at cycle n gives busy=1 and grant_id valid at n+1. The first beat is possible at n+1.
- Throughput: 1 beat/cycle within a grant. Each grant costs exactly 1 IDLE cycle of overhead.
- Combinational paths:
  - fifo_wr_vld to req_ready;
  - req_valid/req_data to fifo_wr_en/fifo_wr_data.
  - Both go through the registered grant mux only.
- Registered outputs: grant_id, busy and burst_done are registers (burst_done is high in the first IDLE cycle).

## Structure
- Package `fifo_arb_pkg` holds:
  - state enum {IDLE, BURST};
  - function clog2;
  - the width constants derived from NUM_REQ and BURST_LEN.
- Sub-module `fifo_arb_rr_pick`: combinational rotating-priority picker.
  - Inputs: req vector, rr_ptr.
  - Outputs: any, idx.
  - Implemented as double-width vector masking.
- Top level holds the FSM, counters, grant mux and port steering.

## Test plan
- Reset, then a single request: req_valid=4'b0100 with 3 words, last on the 3rd, fifo_wr_vld=1. Expect grant_id=2 one cycle later, 3 consecutive writes, then burst_done, rr_ptr=3.
- Fairness: all 4 producers valid continuously, BURST_LEN=4, no last. Expect grants in order 0,1,2,3,0, each 4 beats followed by 1 IDLE cycle; 16 beats in 20 cycles.
- Back-pressure: producer 1 with 5 words, fifo_wr_vld low for cycles 2-4 of the burst. Expect fifo_wr_en held, req_ready[1]=0 during the stall, beat_cnt frozen, all 5 words written in order with no duplication.
- Timeout: producer 0 granted, sends 2 words then drops valid, IDLE_TIMEOUT=8. Expect release after 8 idle cycles with burst_done; waiting producer 3 is then granted.
- Last coincides with the limit: BURST_LEN=4, last on the 4th beat. Expect exactly one burst_done pulse and the next grant to (g+1).
- Mid-burst reset: wr_rst asserted for 1 cycle on beat 2. Expect busy=0, fifo_wr_en=0, all req_ready=0 the next cycle; the next grant goes to the lowest valid index starting from 0.
